bip_debug_unit: RTL and testbench
=================================

Name: bip_debug_unit

Overview:
UART-driven run controller for the BIP processor (Control_Block plus datapath plus memories). It gates the CPU with a clock-enable and runs the program either to halt or one instruction at a time. After each run or step it snapshots PC, ACC and an executed-cycle count, then streams them to the host through the UART transmitter. It sits between uart_rx/uart_tx and the CPU top.

Parameters:
ADDR_W, 11, PC width (matches Control_Block address_output)
DATA_W, 16, accumulator width
CNT_W, 8, executed-cycle counter width (saturating)
CMD_RUN, 8'h52, command byte "R": run until halt
CMD_STEP, 8'h53, command byte "S": execute one instruction
CMD_RST, 8'h43, command byte "C": reset CPU and cycle count

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous, active-low reset
rx_data  in  8  received UART byte
rx_done  in  1  one-cycle pulse; rx_data valid
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle pulse; tx_data valid
tx_done  in  1  one-cycle pulse; transmitter finished the current byte
halt  in  1  CPU decoding HLT (OpCode 5'b00000) this cycle
pc  in  ADDR_W  CPU program counter
acc  in  DATA_W  CPU accumulator
bip_en  out  1  CPU clock enable; one instruction per enabled cycle
bip_rst_n  out  1  active-low CPU reset pulse
busy  out  1  high in every state except IDLE and HALTED

Behaviour:
- Reset values: bip_en=0, bip_rst_n=1, tx_start=0, tx_data=0, busy=0, cycle count=0, snapshot=0, byte index=0, state=IDLE.
- All outputs are registered.
- rx_done is accepted only in IDLE or HALTED. In other states it is dropped with no effect.
- Unknown command bytes are ignored.
- FSM states: IDLE, RUN, STEP, SNAP, SEND, WAIT, HALTED, CLR.
- IDLE:
  - rx_done with CMD_RUN -> RUN.
  - rx_done with CMD_STEP -> STEP.
  - rx_done with CMD_RST -> CLR.
- RUN:
  - bip_en=1 starting the cycle after the command (1-cycle latency).
  - Every cycle with bip_en=1 increments the count, saturating at 2^CNT_W-1 (no wrap).
  - When halt=1 is sampled while bip_en=1, that cycle is counted and bip_en=0 from the next cycle. Next state is SNAP with halted flag set.
- STEP:
  - bip_en=1 for exactly one cycle, which is counted.
  - Next state SNAP. The halted flag is set if halt=1 during that cycle.
- SNAP: latch pc, acc and count into the snapshot in one cycle, then byte index=0 -> SEND.
- Byte order:
  - 0: {zero-padded, pc[10:8]}
  - 1: pc[7:0]
  - 2: acc[15:8]
  - 3: acc[7:0]
  - 4: count
- SEND: tx_start=1 for one cycle with tx_data = the indexed byte -> WAIT.
- WAIT: hold tx_data.
  - On tx_done: if index<4, increment index -> SEND.
  - If index=4: go to HALTED when the halted flag is set, else IDLE.
- The transmitter sees back-to-back bytes no sooner than one cycle after tx_done.
- HALTED:
  - bip_en stays 0.
  - CMD_RUN and CMD_STEP are ignored.
  - CMD_RST -> CLR.
- CLR:
  - bip_rst_n=0 for exactly one cycle; count=0; halted flag cleared.
  - Next state IDLE. No bytes are sent.
- halt changes while bip_en=0 have no effect.
- rst_n asserted mid-run or mid-send returns all state to reset values immediately.
  - Any partially sent frame is abandoned.
  - bip_rst_n is not pulsed by rst_n; the CPU has its own reset from rst_n.

Decomposition:
- Shared package bip_debug_pkg holds:
  - the state enum;
  - the command byte constants;
  - FRAME_BYTES=5.
- Natural sub-module: bip_debug_frame_mux. It is combinational and selects the tx byte from the snapshot plus the byte index, keeping the FSM file focused on sequencing.

Test Plan:
- Program "LDI 5; ADDI 3; HLT" at pc 0..2, send 8'h52:
  - bip_en high for exactly 3 cycles.
  - tx bytes in order: 00, 02, 00, 08, 03.
  - End state HALTED, busy=0.
- Same program after CMD_RST, send 8'h53 three times:
  - first frame: 00, 01, 00, 05, 01;
  - second frame: 00, 02, 00, 08, 02;
  - third frame: pc=2, count=03, end state HALTED.
- In HALTED, send 8'h52:
  - no bip_en, no tx_start.
- Then send 8'h43:
  - bip_rst_n low for one cycle, state IDLE.
  - A following 8'h53 reports count=01.
- 300-instruction loop without halt, CNT_W=8: after the run is forced to halt, count byte = FF (saturated).
- Inject rx_done with 8'h52 during WAIT: ignored, and the frame completes unchanged.
- Unknown byte 8'h00 in IDLE: no response.
- Assert rst_n low during SEND byte 2:
  - tx_start stays 0 afterwards, bip_en=0, state IDLE.
  - A new 8'h53 produces a full 5-byte frame with count=01.

Source files
------------

// File: rtl/bip_debug_pkg.sv
// bip_debug_pkg
// Shared constants for the BIP debug unit: host command bytes, frame
// length, byte-index width and the run-controller state encoding.
// The states are plain constants of a 3-bit type so that they remain
// readable in older tools and waveform viewers.
package bip_debug_pkg;

  // Host command bytes (ASCII "R", "S", "C")
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_RST  = 8'h43;

  // Status frame: pc high, pc low, acc high, acc low, cycle count
  localparam int FRAME_BYTES = 5;
  localparam int IDX_W       = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Run-controller states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RUN    = 3'd1;
  localparam state_t ST_STEP   = 3'd2;
  localparam state_t ST_SNAP   = 3'd3;
  localparam state_t ST_SEND   = 3'd4;
  localparam state_t ST_WAIT   = 3'd5;
  localparam state_t ST_HALTED = 3'd6;
  localparam state_t ST_CLR    = 3'd7;

endpackage

// File: rtl/bip_debug_frame_mux.sv
// bip_debug_frame_mux
// Combinational selector for the status frame byte to transmit.
// Ports:
//   snap_pc   in  ADDR_W  captured program counter
//   snap_acc  in  DATA_W  captured accumulator
//   snap_cnt  in  CNT_W   captured executed-cycle count
//   byte_idx  in  IDX_W   frame position 0..FRAME_BYTES-1
//   byte_out  out 8       selected byte
module bip_debug_frame_mux
  import bip_debug_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic [ADDR_W-1:0] snap_pc,
  input  logic [DATA_W-1:0] snap_acc,
  input  logic [CNT_W-1:0]  snap_cnt,
  input  logic [IDX_W-1:0]  byte_idx,
  output logic [7:0]        byte_out
);

  // Fields are zero-extended to whole bytes so the upper pc byte
  // carries only pc[10:8].
  logic [15:0] pc_ext;
  logic [15:0] acc_ext;
  logic [7:0]  cnt_ext;

  assign pc_ext  = 16'(snap_pc);
  assign acc_ext = 16'(snap_acc);
  assign cnt_ext = 8'(snap_cnt);

  always_comb begin
    byte_out = 8'h00;
    case (byte_idx)
      3'd0:    byte_out = pc_ext[15:8];
      3'd1:    byte_out = pc_ext[7:0];
      3'd2:    byte_out = acc_ext[15:8];
      3'd3:    byte_out = acc_ext[7:0];
      3'd4:    byte_out = cnt_ext;
      default: byte_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/bip_debug_unit.sv
// bip_debug_unit
// UART-driven run controller for the BIP CPU. Accepts run / step / clear
// commands from the host, gates the CPU with a clock enable, then reports
// PC, ACC and the saturating executed-cycle count as a 5-byte frame.
// Ports:
//   clk        in  1       system clock
//   rst_n      in  1       asynchronous active-low reset
//   rx_data    in  8       received command byte
//   rx_done    in  1       rx_data valid pulse
//   tx_data    out 8       byte to transmit
//   tx_start   out 1       transmit request pulse
//   tx_done    in  1       transmitter finished current byte
//   halt       in  1       CPU is decoding HLT this cycle
//   pc         in  ADDR_W  CPU program counter
//   acc        in  DATA_W  CPU accumulator
//   bip_en     out 1       CPU clock enable
//   bip_rst_n  out 1       active-low CPU reset pulse
//   busy       out 1       controller is neither IDLE nor HALTED
module bip_debug_unit
  import bip_debug_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] acc,
  output logic              bip_en,
  output logic              bip_rst_n,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q,    state_d;
  logic              bip_en_q,   bip_en_d;
  logic              bip_rst_n_q, bip_rst_n_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q,  tx_data_d;
  logic              busy_q,     busy_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              halted_q,   halted_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [ADDR_W-1:0] snap_pc_q,  snap_pc_d;
  logic [DATA_W-1:0] snap_acc_q, snap_acc_d;
  logic [CNT_W-1:0]  snap_cnt_q, snap_cnt_d;
  logic [7:0]        frame_byte;

  bip_debug_frame_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_frame_mux (
    .snap_pc  (snap_pc_q),
    .snap_acc (snap_acc_q),
    .snap_cnt (snap_cnt_q),
    .byte_idx (idx_q),
    .byte_out (frame_byte)
  );

  // Next-state logic. Commands are only honoured while parked in IDLE or
  // HALTED; everything else runs to completion undisturbed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    halted_d   = halted_q;
    idx_d      = idx_q;
    snap_pc_d  = snap_pc_q;
    snap_acc_d = snap_acc_q;
    snap_cnt_d = snap_cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;

    // Every enabled CPU cycle counts, including the one that decodes HLT.
    if (bip_en_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          case (rx_data)
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_RST:  state_d = ST_CLR;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_HALTED: begin
        if (rx_done && (rx_data == CMD_RST)) begin
          state_d = ST_CLR;
        end
      end
      ST_RUN: begin
        if (halt) begin
          halted_d = 1'b1;
          state_d  = ST_SNAP;
        end
      end
      ST_STEP: begin
        halted_d = halt;
        state_d  = ST_SNAP;
      end
      ST_SNAP: begin
        snap_pc_d  = pc;
        snap_acc_d = acc;
        snap_cnt_d = cnt_q;
        idx_d      = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        tx_start_d = 1'b1;
        tx_data_d  = frame_byte;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_SEND;
          end else begin
            state_d = halted_q ? ST_HALTED : ST_IDLE;
          end
        end
      end
      ST_CLR: begin
        cnt_d    = '0;
        halted_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Level outputs are derived from the next state so they line up with
    // the state register: enable during RUN/STEP, reset during CLR.
    bip_en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
    bip_rst_n_d = (state_d != ST_CLR);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_HALTED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bip_en_q    <= 1'b0;
      bip_rst_n_q <= 1'b1;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
      idx_q       <= '0;
      snap_pc_q   <= '0;
      snap_acc_q  <= '0;
      snap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bip_en_q    <= bip_en_d;
      bip_rst_n_q <= bip_rst_n_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      halted_q    <= halted_d;
      idx_q       <= idx_d;
      snap_pc_q   <= snap_pc_d;
      snap_acc_q  <= snap_acc_d;
      snap_cnt_q  <= snap_cnt_d;
    end
  end

  assign bip_en    = bip_en_q;
  assign bip_rst_n = bip_rst_n_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bip_debug_unit.sv
// tb_bip_debug_unit
// Bench for bip_debug_unit with a tiny BIP-like CPU model and a UART
// transmitter model. Expected frames come from hand-derived tables and
// from an instruction-level reference of the command protocol.
module tb_bip_debug_unit;
  import bip_debug_pkg::*;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 8;
  localparam int MEM_DEPTH = 64;
  localparam logic [1:0] OP_HLT  = 2'd0;
  localparam logic [1:0] OP_LDI  = 2'd1;
  localparam logic [1:0] OP_ADDI = 2'd2;
  localparam logic [1:0] OP_JMP  = 2'd3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_done;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done;
  logic              halt;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic              bip_en;
  logic              bip_rst_n;
  logic              busy;

  bip_debug_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_done   (tx_done),
    .halt      (halt),
    .pc        (pc),
    .acc       (acc),
    .bip_en    (bip_en),
    .bip_rst_n (bip_rst_n),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // CPU model: one instruction per enabled cycle; HLT holds pc.
  logic [1:0]  progOp  [MEM_DEPTH];
  logic [15:0] progArg [MEM_DEPTH];
  logic [10:0] cpuPc;
  logic [15:0] cpuAcc;
  logic        forceHalt;
  logic [1:0]  curOp;
  logic [15:0] curArg;

  assign curOp  = progOp[cpuPc[5:0]];
  assign curArg = progArg[cpuPc[5:0]];
  assign halt   = forceHalt || (curOp == OP_HLT);
  assign pc     = cpuPc;
  assign acc    = cpuAcc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpuPc  <= '0;
      cpuAcc <= '0;
    end else if (!bip_rst_n) begin
      cpuPc  <= '0;
      cpuAcc <= '0;
    end else if (bip_en && !halt) begin
      case (curOp)
        OP_LDI:  begin cpuAcc <= curArg;          cpuPc <= cpuPc + 11'd1; end
        OP_ADDI: begin cpuAcc <= cpuAcc + curArg; cpuPc <= cpuPc + 11'd1; end
        OP_JMP:  cpuPc <= curArg[10:0];
        default: cpuPc <= cpuPc;
      endcase
    end
  end

  // Transmitter model: logs each byte, answers with tx_done 1..4 cycles later.
  logic [7:0] txLog[$];
  int txDelay;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b0;
      txDelay <= 0;
    end else begin
      tx_done <= 1'b0;
      if (tx_start) begin
        txLog.push_back(tx_data);
        txDelay <= int'($urandom_range(4, 1));
      end else if (txDelay > 0) begin
        txDelay <= txDelay - 1;
        if (txDelay == 1) tx_done <= 1'b1;
      end
    end
  end

  // Activity monitors
  int enCycles;
  int rstLowCycles;
  always @(posedge clk) begin
    if (bip_en === 1'b1) enCycles <= enCycles + 1;
    if (bip_rst_n === 1'b0) rstLowCycles <= rstLowCycles + 1;
  end

  int checks;
  int passes;

  task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference model: instruction-level view of the command protocol.
  int refPc;
  int refAcc;
  int refExec;
  bit refHalted;

  function automatic logic [39:0] refFrame();
    logic [15:0] p;
    logic [15:0] a;
    logic [7:0]  c;
    p = 16'(refPc % 2048);
    a = 16'(refAcc % 65536);
    c = (refExec > 255) ? 8'd255 : 8'(refExec);
    return {p[15:8], p[7:0], a[15:8], a[7:0], c};
  endfunction

  task automatic refStepOne();
    int m;
    m = refPc % MEM_DEPTH;
    refExec++;
    case (progOp[m])
      OP_HLT:  refHalted = 1'b1;
      OP_LDI:  begin refAcc = int'(progArg[m]); refPc++; end
      OP_ADDI: begin refAcc = (refAcc + int'(progArg[m])) % 65536; refPc++; end
      default: refPc = int'(progArg[m]) % 2048;
    endcase
  endtask

  task automatic refCommand(input logic [7:0] cmd, output bit frame, output logic [39:0] bytes,
                            output int enExp, output int rstExp);
    frame = 1'b0; bytes = '0; enExp = 0; rstExp = 0;
    if (cmd == CMD_RST) begin
      refPc = 0; refAcc = 0; refExec = 0; refHalted = 1'b0; rstExp = 1;
    end else if (!refHalted && cmd == CMD_STEP) begin
      refStepOne(); enExp = 1; frame = 1'b1; bytes = refFrame();
    end else if (!refHalted && cmd == CMD_RUN) begin
      while (!refHalted && enExp < 10000) begin refStepOne(); enExp++; end
      frame = 1'b1; bytes = refFrame();
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin @(negedge clk); n++; end
    checkOutput({name, " settles idle"}, 40'(busy), 40'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input string name, input logic [7:0] cmd);
    sendByte(cmd);
    waitIdle(name);
  endtask

  task automatic checkFrame(input string name, input int logStart, input bit expFrame, input logic [39:0] expBytes);
    int got;
    got = txLog.size() - logStart;
    checkOutput({name, " byte count"}, 40'(got), expFrame ? 40'd5 : 40'd0);
    if (expFrame && got == 5) begin
      for (int i = 0; i < 5; i++)
        checkOutput($sformatf("%s byte%0d", name, i), 40'(txLog[logStart + i]), 40'(expBytes[39 - 8*i -: 8]));
    end
  endtask

  task automatic doCommand(input string name, input logic [7:0] cmd);
    int logStart, en0, r0, enExp, rstExp;
    bit frame;
    logic [39:0] bytes;
    logStart = txLog.size(); en0 = enCycles; r0 = rstLowCycles;
    refCommand(cmd, frame, bytes, enExp, rstExp);
    applyStimulus(name, cmd);
    checkFrame(name, logStart, frame, bytes);
    checkOutput({name, " en cycles"}, 40'(enCycles - en0), 40'(enExp));
    checkOutput({name, " rst pulses"}, 40'(rstLowCycles - r0), 40'(rstExp));
  endtask

  task automatic loadDemoProgram();
    for (int i = 0; i < MEM_DEPTH; i++) begin progOp[i] = OP_HLT; progArg[i] = 16'h0; end
    progOp[0] = OP_LDI;  progArg[0] = 16'd5;
    progOp[1] = OP_ADDI; progArg[1] = 16'd3;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    bit          expFrame;
    logic [39:0] expBytes;
    int          expEn;
    int          expRst;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int logStart, en0, r0, n, activity;
    bit frame, found;
    logic [39:0] bytes;
    int enExp, rstExp;

    vecs[0]  = '{CMD_RUN,  1'b1, 40'h00_02_00_08_03, 3, 0};
    vecs[1]  = '{CMD_RUN,  1'b0, 40'h0,              0, 0};
    vecs[2]  = '{CMD_STEP, 1'b0, 40'h0,              0, 0};
    vecs[3]  = '{CMD_RST,  1'b0, 40'h0,              0, 1};
    vecs[4]  = '{CMD_STEP, 1'b1, 40'h00_01_00_05_01, 1, 0};
    vecs[5]  = '{CMD_STEP, 1'b1, 40'h00_02_00_08_02, 1, 0};
    vecs[6]  = '{CMD_STEP, 1'b1, 40'h00_02_00_08_03, 1, 0};
    vecs[7]  = '{CMD_RUN,  1'b0, 40'h0,              0, 0};
    vecs[8]  = '{CMD_RST,  1'b0, 40'h0,              0, 1};
    vecs[9]  = '{CMD_STEP, 1'b1, 40'h00_01_00_05_01, 1, 0};
    vecs[10] = '{8'h00,    1'b0, 40'h0,              0, 0};
    vecs[11] = '{8'h99,    1'b0, 40'h0,              0, 0};

    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; forceHalt = 1'b0;
    loadDemoProgram();
    refPc = 0; refAcc = 0; refExec = 0; refHalted = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset bip_en", 40'(bip_en), 40'd0);
    checkOutput("reset bip_rst_n", 40'(bip_rst_n), 40'd1);
    checkOutput("reset tx_start", 40'(tx_start), 40'd0);
    checkOutput("reset tx_data", 40'(tx_data), 40'd0);
    checkOutput("reset busy", 40'(busy), 40'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post-reset busy", 40'(busy), 40'd0);
    checkOutput("post-reset bip_en", 40'(bip_en), 40'd0);

    // halt toggling while disabled does nothing
    en0 = enCycles; logStart = txLog.size();
    forceHalt = 1'b1;
    repeat (3) @(negedge clk);
    forceHalt = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle halt en", 40'(enCycles - en0), 40'd0);
    checkOutput("idle halt tx", 40'(txLog.size() - logStart), 40'd0);
    checkOutput("idle halt busy", 40'(busy), 40'd0);

    // Directed command table on LDI 5; ADDI 3; HLT
    for (int v = 0; v < 12; v++) begin
      logStart = txLog.size(); en0 = enCycles; r0 = rstLowCycles;
      refCommand(vecs[v].cmd, frame, bytes, enExp, rstExp);
      applyStimulus($sformatf("vec%0d", v), vecs[v].cmd);
      checkFrame($sformatf("vec%0d", v), logStart, vecs[v].expFrame, vecs[v].expBytes);
      checkOutput($sformatf("vec%0d en cycles", v), 40'(enCycles - en0), 40'(vecs[v].expEn));
      checkOutput($sformatf("vec%0d rst pulses", v), 40'(rstLowCycles - r0), 40'(vecs[v].expRst));
    end

    // Command injected during WAIT is dropped; frame completes unchanged
    logStart = txLog.size(); en0 = enCycles;
    refCommand(CMD_STEP, frame, bytes, enExp, rstExp);
    sendByte(CMD_STEP);
    found = 1'b0; n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      if (tx_start) found = 1'b1;
      n++;
    end
    checkOutput("inject saw tx_start", 40'(found), 40'd1);
    rx_data = CMD_RUN; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; rx_data = 8'h00;
    waitIdle("inject");
    checkFrame("inject", logStart, 1'b1, 40'h00_02_00_08_02);
    checkOutput("inject en cycles", 40'(enCycles - en0), 40'd1);

    // rst_n during SEND of byte 2 abandons the frame
    logStart = txLog.size();
    sendByte(CMD_STEP);
    found = 1'b0; n = 0;
    while (!found && n < 300) begin
      @(negedge clk);
      if (tx_start && (txLog.size() - logStart == 2)) found = 1'b1;
      n++;
    end
    checkOutput("rst mid-send reached byte2", 40'(found), 40'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    refPc = 0; refAcc = 0; refExec = 0; refHalted = 1'b0;
    activity = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_start || bip_en || busy) activity++;
    end
    checkOutput("rst mid-send quiet", 40'(activity), 40'd0);
    checkOutput("rst mid-send partial bytes", 40'(txLog.size() - logStart), 40'd2);
    logStart = txLog.size();
    doCommand("after rst step", CMD_STEP);
    checkFrame("after rst frame", logStart, 1'b1, 40'h00_01_00_05_01);

    // Saturation: endless loop, halt forced after 300 enabled cycles
    doCommand("sat clear", CMD_RST);
    progOp[0] = OP_ADDI; progArg[0] = 16'd1;
    progOp[1] = OP_JMP;  progArg[1] = 16'd0;
    logStart = txLog.size(); en0 = enCycles;
    sendByte(CMD_RUN);
    n = 0;
    while ((enCycles - en0) < 300 && n < 1000) begin @(negedge clk); n++; end
    checkOutput("sat reached 300", 40'(enCycles - en0), 40'd300);
    forceHalt = 1'b1;
    @(negedge clk);
    forceHalt = 1'b0;
    waitIdle("sat");
    checkFrame("sat", logStart, 1'b1, 40'h00_00_00_96_FF);
    checkOutput("sat en cycles", 40'(enCycles - en0), 40'd301);
    refHalted = 1'b1;
    doCommand("sat halted run", CMD_RUN);
    doCommand("sat clear2", CMD_RST);

    // Randomized programs and command streams against the reference
    for (int it = 0; it < 25; it++) begin
      int len, k, pick;
      logic [7:0] cmd;
      doCommand($sformatf("rnd%0d clear", it), CMD_RST);
      for (int i = 0; i < MEM_DEPTH; i++) begin progOp[i] = OP_HLT; progArg[i] = 16'h0; end
      len = int'($urandom_range(6, 0));
      for (int i = 0; i < len; i++) begin
        progOp[i]  = ($urandom_range(1, 0) == 0) ? OP_LDI : OP_ADDI;
        progArg[i] = 16'($urandom());
      end
      k = int'($urandom_range(6, 1));
      for (int j = 0; j < k; j++) begin
        pick = int'($urandom_range(7, 0));
        if (pick <= 3) cmd = CMD_STEP;
        else if (pick <= 5) cmd = CMD_RUN;
        else if (pick == 6) begin
          cmd = 8'($urandom());
          while (cmd == CMD_RUN || cmd == CMD_STEP || cmd == CMD_RST) cmd = 8'($urandom());
        end else cmd = CMD_RST;
        doCommand($sformatf("rnd%0d.%0d cmd%0h", it, j, cmd), cmd);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
